// File: rtl/prv32_mdu_if.sv
// Handshake/operand bundle between the execute stage and the RV32M multiply/divide unit.
interface prv32_mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] r;

    // Execute stage side: issues operations, watches busy/done/result.
    modport master (
        output start, funct3, a, b, flush,
        input  busy, done, r
    );

    // Unit side.
    modport slave (
        input  start, funct3, a, b, flush,
        output busy, done, r
    );
endinterface

// File: rtl/prv32_mdu.sv
// Iterative RV32M multiply/divide unit. A shift-add multiplier and a restoring
// divider share one 2*XLEN working register; every op takes 32 CALC cycles plus
// one FIX cycle, then pulses done with the result registered on r.
module prv32_mdu #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    prv32_mdu_if.slave bus
);
    localparam int W = XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [4:0]     count_reg;
    logic [2*W-1:0] work_reg;     // mul: {acc, multiplier}; div: {rem, quot}
    logic [W-1:0]   opnd_reg;     // mul: |multiplicand|; div: |divisor|
    logic [W-1:0]   a_raw_reg;    // original dividend for the divide-by-zero remainder
    logic [2:0]     op_reg;
    logic           neg_a_reg;
    logic           neg_b_reg;
    logic           div0_reg;
    logic           ovf_reg;
    logic [W-1:0]   r_reg;
    logic           done_reg;

    // Launch-time decode of operand signedness and magnitudes.
    logic           a_signed, b_signed, neg_a_in, neg_b_in;
    logic [W-1:0]   a_abs, b_abs;
    logic           div0_in, ovf_in;

    always_comb begin
        a_signed = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                   (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        neg_a_in = a_signed && bus.a[W-1];
        neg_b_in = b_signed && bus.b[W-1];
        a_abs    = neg_a_in ? (~bus.a + 1'b1) : bus.a;
        b_abs    = neg_b_in ? (~bus.b + 1'b1) : bus.b;
        div0_in  = (bus.b == '0);
        ovf_in   = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                   (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == {W{1'b1}});
    end

    // One iteration of the multiplier and of the divider.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;
    logic [2*W:0]   div_shift;
    logic [W:0]     div_rem;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] div_step;

    always_comb begin
        // Multiply: conditional add into the upper half with carry, then shift right.
        mul_sum  = {1'b0, work_reg[2*W-1:W]} + {1'b0, opnd_reg};
        mul_step = work_reg[0] ? {mul_sum, work_reg[W-1:1]}
                               : {1'b0, work_reg[2*W-1:1]};
        // Divide: shift {rem, quot} left; the shifted remainder needs W+1 bits
        // but after subtraction always fits back into W bits.
        div_shift = {work_reg, 1'b0};
        div_rem   = div_shift[2*W:W];
        div_ge    = (div_rem >= {1'b0, opnd_reg});
        div_diff  = div_rem[W-1:0] - opnd_reg;
        div_step  = div_ge ? {div_diff, div_shift[W-1:1], 1'b1}
                           : div_shift[2*W-1:0];
    end

    // Sign fix-up, result select and special-case overrides for the FIX cycle.
    logic [2*W-1:0] product;
    logic [W-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        product  = (neg_a_reg ^ neg_b_reg) ? (~work_reg + 1'b1) : work_reg;
        quot_fix = (neg_a_reg ^ neg_b_reg) ? (~work_reg[W-1:0] + 1'b1) : work_reg[W-1:0];
        rem_fix  = neg_a_reg ? (~work_reg[2*W-1:W] + 1'b1) : work_reg[2*W-1:W];
        if (div0_reg) begin
            quot_fix = {W{1'b1}};
            rem_fix  = a_raw_reg;
        end
        if (ovf_reg) begin
            quot_fix = {1'b1, {(W-1){1'b0}}};
            rem_fix  = '0;
        end
        case (op_reg)
            3'b000:                 fix_result = product[W-1:0];
            3'b001, 3'b010, 3'b011: fix_result = product[2*W-1:W];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere and beats start.
    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (bus.start) state_next = S_CALC;
                S_CALC:  if (count_reg == 5'd31) state_next = S_FIX;
                S_FIX:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, and result/done registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            work_reg  <= '0;
            opnd_reg  <= '0;
            a_raw_reg <= '0;
            op_reg    <= '0;
            neg_a_reg <= 1'b0;
            neg_b_reg <= 1'b0;
            div0_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            r_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.flush) begin
                count_reg <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.start) begin
                            op_reg    <= bus.funct3;
                            neg_a_reg <= neg_a_in;
                            neg_b_reg <= neg_b_in;
                            div0_reg  <= div0_in;
                            ovf_reg   <= ovf_in;
                            a_raw_reg <= bus.a;
                            count_reg <= '0;
                            if (bus.funct3[2]) begin
                                work_reg <= {{W{1'b0}}, a_abs};
                                opnd_reg <= b_abs;
                            end else begin
                                work_reg <= {{W{1'b0}}, b_abs};
                                opnd_reg <= a_abs;
                            end
                        end
                    end
                    S_CALC: begin
                        work_reg  <= op_reg[2] ? div_step : mul_step;
                        count_reg <= count_reg + 5'd1;
                    end
                    S_FIX: begin
                        r_reg    <= fix_result;
                        done_reg <= 1'b1;
                    end
                    default: begin
                        count_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = (state_reg != S_IDLE);
    assign bus.done = done_reg;
    assign bus.r    = r_reg;

endmodule

// File: doc/prv32_mdu.md
# prv32_mdu

Iterative RV32M multiply/divide unit sitting in the execute stage beside `prv32_ALU`. It takes the same forwarded operands `a`/`b` as the ALU and returns a 32-bit result that the writeback select mux picks in place of the ALU result `r`. A sequential shift-add multiplier and a restoring divider share one 64-bit working register. While the unit runs, the pipeline stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  32  rs1 operand (dividend / multiplicand).
- `b`  in  32  rs2 operand (divisor / multiplier).
- `flush`  in  1  synchronous abort from branch/exception redirect.
- `busy`  out  1  unit occupied; the hazard unit stalls IF/ID/EX while high.
- `done`  out  1  one-cycle pulse; `r` is valid.
- `r`  out  32  result; held until the next accepted `start`.

## Operation
- Reset (`rst_n` low, asynchronous): state IDLE, count 0, `busy`=0, `done`=0, `r`=0, working registers cleared. This applies mid-operation too; no `done` is produced for the aborted op.
- **IDLE**
  - `start`=1 and `flush`=0: latch `funct3`, the operand signs and |a|, |b|. Take the absolute value only for signed operands: a is signed for MUL/MULH/MULHSU/DIV/REM; b is signed for MUL/MULH/DIV/REM.
  - Special cases are detected and flagged at launch, then go to CALC.
  - `start` asserted while not IDLE is ignored. The hazard unit guarantees it is held.
- **CALC**, 32 cycles, count 0..31:
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half, then shift the 64-bit {acc, multiplier} right by 1 (33-bit add keeps the carry).
  - Divide (restoring): shift {rem, quot} left by 1. If rem ≥ divisor, subtract it and set the quot LSB.
  - At count 31, go to FIX.
- **FIX**, 1 cycle:
  - Negate the 64-bit product when the operand signs differ (signed views only).
  - Negate the quotient when the dividend and divisor signs differ. Negate the remainder when the dividend is negative.
  - Select the result: MUL → low 32; MULH/MULHSU/MULHU → high 32; DIV/DIVU → quotient; REM/REMU → remainder.
  - Apply overrides:
    - Divide by zero: quotient = 0xFFFFFFFF, remainder = a.
    - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
  - Register into `r`, pulse `done`, return to IDLE.
- Latency is fixed for all ops, including special cases. There is no early termination.
- `flush`=1 in any state: next state IDLE, `busy`=0, no `done`, `r` unchanged. A flush with simultaneous `start` in IDLE wins; nothing is launched.

## Timing
- Let E0 be the edge that samples `start`.
- `busy` is 1 after E0 through the edge that enters FIX+1, i.e. 33 cycles.
- `done` is 1 for exactly the one cycle after E0+33. In that cycle `busy`=0 and `r` is valid.
- A new `start` may be sampled in the same cycle `done` is high, giving back-to-back ops.
- Operands are captured at E0. Changes to `a`/`b`/`funct3` after E0 have no effect.
- `done` and `busy` are never both 1.

## Test plan
- **Multiply.**
  - MUL a=7, b=0xFFFFFFFD (−3) → `r`=0xFFFFFFEB. `done` must be high exactly in the cycle after E0+33, with `busy` low in that cycle.
  - MULH a=b=0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide.**
  - DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
- **Divide by zero.**
  - DIVU a=5, b=0 → 0xFFFFFFFF.
  - REM a=0xFFFFFFF9, b=0 → 0xFFFFFFF9.
  - Both complete with the same 34-cycle timing.
- **Signed overflow.** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Flush.**
  - Assert `flush` at count 10 → `busy` drops next cycle, no `done` ever, `r` keeps its prior value.
  - A following MUL 3×4 → 12 with normal latency.
- **Reset and start handling.**
  - Drop `rst_n` asynchronously mid-CALC → `busy`/`done`/`r` read 0 immediately.
  - Pulse `start` again while busy → ignored; only one `done`.
  - Back-to-back: `start` in the `done` cycle → second result 34 cycles later.
